// File: rtl/mux_channel_scanner.sv
// Sweeps the select of a NUM_CH:1 mux and assembles every channel's output into one
// packed frame, then hands the frame downstream on a valid/ready handshake.
module mux_channel_scanner #(
  parameter int NUM_CH = 32,
  parameter int SEL_W  = 5,
  parameter int DATA_W = 2,
  parameter int SETTLE = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     continuous,
  input  logic                     abort,
  input  logic [NUM_CH-1:0]        en_mask,
  output logic [SEL_W-1:0]         sel,
  input  logic [DATA_W-1:0]        mux_out,
  output logic [NUM_CH*DATA_W-1:0] frame,
  output logic                     frame_valid,
  input  logic                     frame_ready,
  output logic                     busy,
  output logic [7:0]               frame_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    VALID = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [SEL_W-1:0]                ch;
  logic [3:0]                      cnt;
  logic [NUM_CH-1:0]               mask;
  logic [NUM_CH-1:0][DATA_W-1:0]   slots;
  logic                            kill, launch, handshake, capture, last_ch;

  // abort only acts outside IDLE; in IDLE it just blocks a start
  assign kill      = abort && (state != IDLE);
  assign handshake = (state == VALID) && frame_ready;
  assign launch    = !abort && (((state == IDLE) && start) || (handshake && continuous));
  assign last_ch   = (ch == SEL_W'(NUM_CH - 1));
  // disabled channels are written with zero on their first edge, no settle dwell
  assign capture   = (state == SCAN) && !abort && (!mask[ch] || (cnt == 4'(SETTLE)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch) state_nxt = SCAN;
      SCAN:    if (kill) state_nxt = IDLE;
               else if (capture && last_ch) state_nxt = VALID;
      VALID:   if (kill) state_nxt = IDLE;
               else if (handshake) state_nxt = continuous ? SCAN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch    <= '0;
      cnt   <= '0;
      mask  <= '0;
      slots <= '0;
    end else if (kill) begin
      ch  <= '0;
      cnt <= '0;
    end else if (launch) begin
      mask  <= en_mask;
      slots <= '0;
      ch    <= '0;
      cnt   <= '0;
    end else if (capture) begin
      slots[ch] <= mask[ch] ? mux_out : '0;
      cnt       <= '0;
      if (!last_ch) ch <= ch + 1'b1;
    end else if (state == SCAN) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     frame_cnt <= '0;
    else if (handshake && !abort)  frame_cnt <= frame_cnt + 1'b1;
  end

  assign sel         = ch;
  assign frame       = slots;
  assign frame_valid = (state == VALID);
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_mux_channel_scanner.sv
// Randomized bench for mux_channel_scanner; expectations come from a per-channel table
// model of the mux and simple sums over the enable mask.
module tb_mux_channel_scanner;
  localparam int NUM_CH = 32;
  localparam int SEL_W  = 5;
  localparam int DATA_W = 2;
  localparam int SETTLE = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0, continuous = 1'b0, abort = 1'b0, frame_ready = 1'b0;
  logic [31:0] en_mask = '0;
  logic [4:0]  sel;
  logic [1:0]  mux_out;
  logic [63:0] frame;
  logic        frame_valid, busy;
  logic [7:0]  frame_cnt;

  logic [1:0]  tbl [NUM_CH];
  logic        noise_on = 1'b0;
  logic [1:0]  noise = '0;
  int          dwell [NUM_CH];
  int          vecs = 0, errs = 0;
  logic [7:0]  exp_cnt = '0;

  always #5 clk = ~clk;

  assign mux_out = noise_on ? noise : tbl[sel];

  mux_channel_scanner #(.NUM_CH(NUM_CH), .SEL_W(SEL_W), .DATA_W(DATA_W), .SETTLE(SETTLE)) dut (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous), .abort(abort),
    .en_mask(en_mask), .sel(sel), .mux_out(mux_out), .frame(frame),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .busy(busy), .frame_cnt(frame_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] exp_frame(input logic [31:0] m);
    logic [63:0] r = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (m[k]) r[2*k +: 2] = tbl[k];
    return r;
  endfunction

  function automatic int exp_lat(input logic [31:0] m);
    int n = 0;
    for (int k = 0; k < NUM_CH; k++) n += m[k] ? SETTLE + 1 : 1;
    return n;
  endfunction

  task automatic rand_tbl();
    for (int k = 0; k < NUM_CH; k++) tbl[k] = 2'($urandom_range(0, 3));
  endtask

  task automatic start_scan(input logic [31:0] m);
    en_mask = m;
    start = 1'b1;
    step();
    start = 1'b0;
    foreach (dwell[k]) dwell[k] = 0;
    chk("busy_at_start", {63'd0, busy}, 64'd1);
    chk("sel_at_start", {59'd0, sel}, 64'd0);
    chk("frame_cleared", frame, 64'd0);
  endtask

  task automatic wait_valid(input logic [31:0] m);
    int n = 0, idle_seen = 0;
    while (!frame_valid && n < 200) begin
      if (!busy) idle_seen++;
      else dwell[sel]++;
      step();
      n++;
    end
    chk("latency", 64'(n), 64'(exp_lat(m)));
    chk("busy_during_scan", 64'(idle_seen), 64'd0);
    chk("frame", frame, exp_frame(m));
  endtask

  task automatic handshake_single();
    frame_ready = 1'b1;
    step();
    frame_ready = 1'b0;
    exp_cnt++;
    chk("hs_valid_drop", {63'd0, frame_valid}, 64'd0);
    chk("hs_idle", {63'd0, busy}, 64'd0);
    chk("hs_frame_cnt", {56'd0, frame_cnt}, {56'd0, exp_cnt});
  endtask

  initial begin
    logic [31:0] m, pend;
    logic [63:0] held;
    int guard, frames, since;

    for (int k = 0; k < NUM_CH; k++) tbl[k] = 2'(k % 4);
    #1 reset = 1'b1;
    #2;
    chk("rst_frame", frame, 64'd0);
    chk("rst_valid", {63'd0, frame_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_sel", {59'd0, sel}, 64'd0);
    chk("rst_cnt", {56'd0, frame_cnt}, 64'd0);
    step(); step();
    reset = 1'b0;
    step();

    // full mask, channel k reads k mod 4
    start_scan(32'hFFFF_FFFF);
    wait_valid(32'hFFFF_FFFF);
    chk("full_frame_const", frame, 64'hE4E4_E4E4_E4E4_E4E4);
    handshake_single();

    // upper half disabled: one-cycle dwell and zero slices there
    start_scan(32'h0000_FFFF);
    wait_valid(32'h0000_FFFF);
    chk("half_frame_const", frame, 64'h0000_0000_E4E4_E4E4);
    for (int k = 0; k < NUM_CH; k++)
      chk($sformatf("dwell_ch%0d", k), 64'(dwell[k]), (k < 16) ? 64'(SETTLE + 1) : 64'd1);
    handshake_single();

    // hold in VALID while mux output toggles, then continuous restart
    rand_tbl();
    m = $urandom;
    start_scan(m);
    wait_valid(m);
    held = exp_frame(m);
    noise_on = 1'b1;
    for (int i = 0; i < 10; i++) begin
      noise = 2'($urandom_range(0, 3));
      step();
      chk("hold_frame", frame, held);
      chk("hold_valid", {63'd0, frame_valid}, 64'd1);
    end
    noise_on = 1'b0;
    pend = $urandom;
    en_mask = pend;
    continuous = 1'b1;
    frame_ready = 1'b1;
    step();
    frame_ready = 1'b0;
    continuous = 1'b0;
    exp_cnt++;
    chk("cont_valid_drop", {63'd0, frame_valid}, 64'd0);
    chk("cont_sel0", {59'd0, sel}, 64'd0);
    chk("cont_busy", {63'd0, busy}, 64'd1);
    chk("cont_frame_clr", frame, 64'd0);
    chk("cont_cnt", {56'd0, frame_cnt}, {56'd0, exp_cnt});
    en_mask = $urandom;
    wait_valid(pend);
    handshake_single();

    // ignored start mid-scan, then abort at sel 7
    rand_tbl();
    start_scan(32'hFFFF_FFFF);
    guard = 0;
    while (sel != 5'd3 && guard < 100) begin step(); guard++; end
    start = 1'b1;
    step();
    start = 1'b0;
    chk("no_restart", {63'd0, (sel >= 5'd3)}, 64'd1);
    guard = 0;
    while (sel != 5'd7 && guard < 100) begin step(); guard++; end
    chk("reach_sel7", {59'd0, sel}, 64'd7);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_sel", {59'd0, sel}, 64'd0);
    chk("abort_valid", {63'd0, frame_valid}, 64'd0);
    chk("abort_cnt", {56'd0, frame_cnt}, {56'd0, exp_cnt});
    chk("abort_partial", frame, exp_frame(32'h0000_007F));
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    chk("start_with_abort", {63'd0, busy}, 64'd0);

    // random single-shot scans
    for (int t = 0; t < 5; t++) begin
      rand_tbl();
      m = $urandom;
      start_scan(m);
      wait_valid(m);
      handshake_single();
    end

    // continuous with ready high across the frame_cnt wrap, mask re-latched per frame
    rand_tbl();
    m = $urandom;
    pend = m;
    continuous = 1'b1;
    frame_ready = 1'b1;
    start_scan(m);
    frames = 0;
    since = 0;
    guard = 0;
    while (frames < 256 && guard < 40000) begin
      if (frame_valid) begin
        chk("wrap_lat", 64'(since), 64'(exp_lat(pend)));
        chk("wrap_frame", frame, exp_frame(pend));
        chk("wrap_cnt", {56'd0, frame_cnt}, {56'd0, exp_cnt});
        pend = $urandom;
        en_mask = pend;
        exp_cnt++;
        frames++;
        step();
        since = 0;
      end else begin
        step();
        since++;
      end
      guard++;
    end
    chk("wrap_frames", 64'(frames), 64'd256);
    chk("wrap_cnt_final", {56'd0, frame_cnt}, {56'd0, exp_cnt});
    guard = 0;
    while (!frame_valid && guard < 200) begin step(); guard++; end
    chk("pre_abort_valid", {63'd0, frame_valid}, 64'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    continuous = 1'b0;
    frame_ready = 1'b0;
    chk("abort_hs_cnt", {56'd0, frame_cnt}, {56'd0, exp_cnt});
    chk("abort_hs_busy", {63'd0, busy}, 64'd0);

    // asynchronous reset while a frame is presented
    m = $urandom;
    start_scan(m);
    wait_valid(m);
    #3 reset = 1'b1;
    #1;
    chk("async_frame", frame, 64'd0);
    chk("async_valid", {63'd0, frame_valid}, 64'd0);
    chk("async_busy", {63'd0, busy}, 64'd0);
    chk("async_sel", {59'd0, sel}, 64'd0);
    chk("async_cnt", {56'd0, frame_cnt}, 64'd0);
    step();
    reset = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/mux_channel_scanner.md
Name: mux_channel_scanner

Overview:
Sequencer that drives the 5-bit select of the 32:1 2-bit channel mux and captures the 2-bit mux output for every channel into one packed frame register. Sits around the mux: its sel output feeds the mux select, and the mux output returns on mux_out. One full sweep of all 32 channels produces one frame, handed downstream on a valid/ready handshake. Supports single-shot and continuous scanning, per-channel enable mask and abort.

Parameters:
NUM_CH, 32, number of mux channels scanned (power of two, at least 2).
SEL_W, 5, select width; equals log2(NUM_CH).
DATA_W, 2, width of each mux channel.
SETTLE, 1, extra cycles sel is held before sampling an enabled channel (0 to 15).

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  single-cycle request to begin a scan; sampled only in IDLE.
continuous  input  1  when 1, a new scan starts automatically after each frame handshake.
abort  input  1  synchronous; returns the block to IDLE from any state.
en_mask  input  NUM_CH  per-channel enable; latched at scan start.
sel  output  SEL_W  mux select currently driven.
mux_out  input  DATA_W  mux output for the current sel.
frame  output  NUM_CH*DATA_W  packed result; channel k occupies bits [DATA_W*k+DATA_W-1 : DATA_W*k].
frame_valid  output  1  frame is complete and stable.
frame_ready  input  1  downstream accepts frame when high together with frame_valid.
busy  output  1  high in any state other than IDLE.
frame_cnt  output  8  count of accepted frames; wraps 255 to 0.

Behaviour:
- Reset (async, any time): state IDLE; sel=0, frame=0, frame_valid=0, busy=0, frame_cnt=0; internal channel and settle counters 0; latched mask 0.
- States: IDLE, SCAN, VALID.
- IDLE: on a start edge with abort=0, latch en_mask, clear frame to 0, set ch=0, sel=0, cnt=0, and go to SCAN. start with abort=1 is ignored.
- SCAN, enabled channel ch: hold sel=ch. cnt increments each edge until cnt==SETTLE. On the edge where cnt==SETTLE, write mux_out into the frame slice for ch. Each enabled channel takes SETTLE+1 edges.
- SCAN, disabled channel ch: on the first edge, write 0 into the slice for ch and advance, with no settle. Takes 1 edge.
- Advance: if ch<NUM_CH-1, then ch+1, sel=ch+1, cnt=0. If ch==NUM_CH-1, go to VALID and set frame_valid=1 on that same edge. sel stays at NUM_CH-1.
- Full-enable latency with SETTLE=1: frame_valid rises on the 64th edge after the start-sampling edge.
- VALID: frame and frame_valid are held stable while frame_ready=0. On an edge with frame_valid and frame_ready both high:
  - frame_cnt increments.
  - If continuous=1: re-latch en_mask, clear frame, ch=0, sel=0, cnt=0, go to SCAN. frame_valid drops on that edge.
  - Otherwise: go to IDLE with frame_valid=0. The frame contents are retained until the next scan start.
- start is ignored outside IDLE. Changes to en_mask after latching have no effect on the current scan.
- abort=1 at an edge in SCAN or VALID: go to IDLE, frame_valid=0, sel=0. frame_cnt is unchanged. A partial frame is not flushed. If abort and a handshake coincide, abort wins and frame_cnt does not increment.
- Reset asserted mid-scan or in VALID: all outputs immediately take their reset values.
- mux_out is sampled only on capture edges; its value at any other time is don't-care.

Test Plan:
- Reset during VALID with frame_valid=1: all outputs go to 0 immediately, without waiting for a clock edge.
- SETTLE=1, en_mask=all ones, mux model returns channel k as k mod 4, start pulse: frame_valid rises 64 edges after start. frame = 0xE4E4E4E4E4E4E4E4. busy=1 throughout the scan. frame_ready=1 moves the block to IDLE with frame_cnt=1.
- en_mask=0x0000FFFF, same mux model: frame_valid after 48 edges. frame = 0x00000000E4E4E4E4. Channels 16 to 31 read 0 and their sel dwell is one cycle.
- frame_ready held low for 10 cycles in VALID while mux_out toggles: frame and frame_valid stay constant. After the handshake, continuous=1 starts a new scan with sel=0 on the next cycle.
- abort asserted at sel=7 mid-scan: next cycle is IDLE, busy=0, sel=0, frame_valid=0, frame_cnt unchanged. A start pulse during SCAN does not restart the scan.
- continuous=1 with frame_ready tied high for 256 frames: frame_cnt wraps to 0. A handshake with simultaneous abort leaves frame_cnt unchanged.
